frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
// Top-level game sequencer for the piano-tiles core. It owns the frame cadence and starts each game.
// Per frame it issues one step to the logic engine, then shares the VGA renderer between the
// erase pass and the draw pass. It holds game-over (won/lost) until the next start.
// PARAMETERS
// FRAME_CYCLES   1666666  clk cycles per frame (30 fps @ 50 MHz); >= 2
// CNT_W          21       frame-divider width; must hold FRAME_CYCLES-1
// NUM_ROWS       5        tile rows erased/drawn per frame (one 4-bit key lane group per row)
// ROW_W          3        width of draw_row; 2**ROW_W >= NUM_ROWS
// LOGIC_TIMEOUT  64       max cycles to wait for logic_done after logic_step
// PORTS
// clk          in   1      system clock
// resetn       in   1      synchronous, active-low reset
// start        in   1      level; rising edge starts/restarts a game
// logic_done   in   1      logic engine finished the step (1-cycle pulse or level)
// won          in   1      engine won flag, valid when logic_done
// lost         in   1      engine lost flag, valid when logic_done
// draw_ack     in   1      renderer finished current row
// load_song    out  1      1-cycle pulse: engine latches song, resets its state
// logic_step   out  1      1-cycle pulse: engine advances one frame
// draw_req     out  1      renderer request, held until draw_ack
// draw_row     out  ROW_W  row index for current request
// erase        out  1      1 = paint background at row, 0 = paint tile
// game_over    out  1      high in WON/LOST
// game_won     out  1      high in WON only
// frame_count  out  16     frames completed this game, saturating at 16'hFFFF
// overrun      out  1      sticky: a frame tick arrived outside WAIT_TICK
// BEHAVIOUR
// - Reset (resetn=0 at posedge, any state): state=IDLE; all outputs 0; divider=0; start edge reg=0.
// - start_rise = start & ~start_q (start_q registered). Ignored in every state except IDLE/WON/LOST.
// - Divider counts 0..FRAME_CYCLES-1 and wraps. tick = (cnt==FRAME_CYCLES-1); it is held at 0 in IDLE.
//   The divider clears on entry to LOAD.
// - FSM states and transitions:
//   IDLE       -start_rise-> LOAD
//   LOAD       load_song=1 for 1 cycle; frame_count=0, overrun=0 -> WAIT_TICK
//   WAIT_TICK  -tick-> ERASE (row=0, erase=1)
//   ERASE      draw_req=1; on draw_req&draw_ack: if row==NUM_ROWS-1 -> STEP, else row+1 (req stays high)
//   STEP       logic_step=1 for 1 cycle; timeout ctr=0 -> WAIT_LOGIC
//   WAIT_LOGIC on logic_done: lost -> LOST; else won -> WON; else DRAW (row=0, erase=0);
//              if ctr reaches LOGIC_TIMEOUT-1 without logic_done -> LOST
//   DRAW       same handshake as ERASE; after last row: frame_count+1 (saturating) -> WAIT_TICK
//   WON/LOST   game_over=1 (game_won=1 in WON); -start_rise-> LOAD
// - Lost has priority when won and lost are both set. The last frame is not drawn.
// - Handshake: draw_row and erase are stable while draw_req=1 and draw_ack=0. draw_ack with draw_req=0 is ignored.
// - A tick while state!=WAIT_TICK sets overrun and is dropped (not queued). The frame finishes normally.
// - start_rise together with tick in WON/LOST: start wins -> LOAD.
// - All outputs are registered; logic_step/load_song are high exactly one cycle per entry.
// STRUCTURE
// - Package piano_pkg: state enum (IDLE, LOAD, WAIT_TICK, ERASE, STEP, WAIT_LOGIC, DRAW, WON, LOST)
//   and the NUM_ROWS/ROW_W defaults shared with the renderer and the logic engine.
// - Sub-module frame_tick_gen (divider + enable + clear, outputs tick). FSM, row counter,
//   timeout counter and frame counter stay in this module.
// TESTING (bench uses FRAME_CYCLES=10, NUM_ROWS=5, LOGIC_TIMEOUT=8; renderer acks 2 cycles after req)
// - Reset then start 0->1: load_song pulses once; no draw_req before first tick; overrun=0.
// - Normal frame: 5 erase reqs (rows 0..4, erase=1), 1 logic_step, logic_done=1 with won=lost=0,
//   5 draw reqs (erase=0); frame_count 0->1.
// - logic_done with won=1,lost=1 -> LOST, game_over=1, game_won=0, no DRAW reqs; start re-rise -> load_song.
// - logic_done never asserted -> LOST exactly 8 cycles after logic_step.
// - Renderer acks 15 cycles late -> overrun=1 sticky; next frame still 5+5 reqs; start in LOAD clears overrun.
// - resetn=0 mid-DRAW (draw_req=1) -> next cycle all outputs 0, IDLE; later draw_ack has no effect.

Source files
------------

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
// Package  : piano_pkg
// Brief    : Shared types and defaults for the piano-tiles core (scheduler,
//            renderer and logic engine).
// Revision : 1.0 - initial release
// ============================================================================
package piano_pkg;

  // Tile rows handled per frame and the width of a row index.
  localparam int DEFAULT_NUM_ROWS = 5;
  localparam int DEFAULT_ROW_W    = 3;

  // Game sequencer states.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD       = 4'd1,
    WAIT_TICK  = 4'd2,
    ERASE      = 4'd3,
    STEP       = 4'd4,
    WAIT_LOGIC = 4'd5,
    DRAW       = 4'd6,
    WON        = 4'd7,
    LOST       = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick_gen
// Brief    : Frame-rate divider. Counts 0..FRAME_CYCLES-1 while enabled and
//            flags the last count as the frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 1666666,
  parameter int CNT_W        = 21
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider: clear wins over counting; wraps at the last count of a frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == C_CNT_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  // Tick is suppressed whenever the divider is not enabled.
  assign tick = enable & (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Brief    : Piano-tiles game sequencer. Per frame: erase all rows, step the
//            logic engine, then draw all rows. Holds won/lost until restart.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler
  import piano_pkg::*;
#(
  parameter int FRAME_CYCLES  = 1666666,
  parameter int CNT_W         = 21,
  parameter int NUM_ROWS      = DEFAULT_NUM_ROWS,
  parameter int ROW_W         = DEFAULT_ROW_W,
  parameter int LOGIC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             logic_done,
  input  logic             won,
  input  logic             lost,
  input  logic             draw_ack,
  output logic             load_song,
  output logic             logic_step,
  output logic             draw_req,
  output logic [ROW_W-1:0] draw_row,
  output logic             erase,
  output logic             game_over,
  output logic             game_won,
  output logic [15:0]      frame_count,
  output logic             overrun
);

  localparam int               TO_W       = $clog2(LOGIC_TIMEOUT);
  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(LOGIC_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_start_q;
  logic             w_start_rise;
  logic             w_tick;
  logic [ROW_W-1:0] w_row_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_next;
  logic [TO_W-1:0]  w_to_inc;
  logic             w_frame_done;
  logic             w_xfer;

  assign w_start_rise = start & ~r_start_q;
  assign w_xfer       = draw_req & draw_ack;
  assign w_to_inc     = r_to_cnt + 1'b1;

  frame_tick_gen #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .enable (r_state != IDLE),
    .clear  (w_next == LOAD),
    .tick   (w_tick)
  );

  // Next-state, row and wait-counter decisions.
  always_comb begin
    w_next       = r_state;
    w_row_next   = draw_row;
    w_to_next    = r_to_cnt;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE:      if (w_start_rise) w_next = LOAD;
      LOAD:      w_next = WAIT_TICK;
      WAIT_TICK: begin
        if (w_tick) begin
          w_next     = ERASE;
          w_row_next = '0;
        end
      end
      ERASE: begin
        if (w_xfer) begin
          if (draw_row == C_LAST_ROW) w_next = STEP;
          else                        w_row_next = draw_row + 1'b1;
        end
      end
      STEP: begin
        w_to_next = '0;
        w_next    = WAIT_LOGIC;
      end
      WAIT_LOGIC: begin
        // An answer from the engine beats the give-up counter in the same cycle.
        if (logic_done) begin
          if (lost)     w_next = LOST;
          else if (won) w_next = WON;
          else begin
            w_next     = DRAW;
            w_row_next = '0;
          end
        end else if (w_to_inc == C_TO_LAST) begin
          w_next = LOST;
        end else begin
          w_to_next = w_to_inc;
        end
      end
      DRAW: begin
        if (w_xfer) begin
          if (draw_row == C_LAST_ROW) begin
            w_next       = WAIT_TICK;
            w_frame_done = 1'b1;
          end else begin
            w_row_next = draw_row + 1'b1;
          end
        end
      end
      WON, LOST: if (w_start_rise) w_next = LOAD;
      default:   w_next = IDLE;
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_start_q   <= 1'b0;
      r_to_cnt    <= '0;
      load_song   <= 1'b0;
      logic_step  <= 1'b0;
      draw_req    <= 1'b0;
      draw_row    <= '0;
      erase       <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_start_q  <= start;
      r_to_cnt   <= w_to_next;
      draw_row   <= w_row_next;
      load_song  <= (w_next == LOAD);
      logic_step <= (w_next == STEP);
      draw_req   <= (w_next == ERASE) || (w_next == DRAW);
      erase      <= (w_next == ERASE);
      game_over  <= (w_next == WON) || (w_next == LOST);
      game_won   <= (w_next == WON);
      if (w_next == LOAD) begin
        frame_count <= '0;
        overrun     <= 1'b0;
      end else begin
        if (w_frame_done && (frame_count != 16'hFFFF)) frame_count <= frame_count + 16'd1;
        // A tick that finds the sequencer busy is dropped but remembered.
        if (w_tick && (r_state != WAIT_TICK)) overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_scheduler
// Brief    : Self-checking bench for frame_scheduler with a renderer stub,
//            a logic-engine stub and a frame-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

  localparam int FRAME_CYCLES  = 10;
  localparam int CNT_W         = 4;
  localparam int NUM_ROWS      = 5;
  localparam int ROW_W         = 3;
  localparam int LOGIC_TIMEOUT = 8;
  // Last WAIT_LOGIC cycle index (from 0) at which logic_done is still honoured.
  localparam int K_MAX         = LOGIC_TIMEOUT - 2;
  localparam int WAIT_BOUND    = 400;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             logic_done = 1'b0;
  logic             won = 1'b0;
  logic             lost = 1'b0;
  logic             draw_ack = 1'b0;
  wire              load_song, logic_step, draw_req, erase, game_over, game_won, overrun;
  wire [ROW_W-1:0]  draw_row;
  wire [15:0]       frame_count;

  frame_scheduler #(
    .FRAME_CYCLES  (FRAME_CYCLES),
    .CNT_W         (CNT_W),
    .NUM_ROWS      (NUM_ROWS),
    .ROW_W         (ROW_W),
    .LOGIC_TIMEOUT (LOGIC_TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .logic_done  (logic_done),
    .won         (won),
    .lost        (lost),
    .draw_ack    (draw_ack),
    .load_song   (load_song),
    .logic_step  (logic_step),
    .draw_req    (draw_req),
    .draw_row    (draw_row),
    .erase       (erase),
    .game_over   (game_over),
    .game_won    (game_won),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({load_song, logic_step, draw_req, draw_row, erase,
                game_over, game_won, frame_count, overrun});
  endfunction

  // ---------------- renderer stub + monitor ----------------
  typedef struct packed { logic e; logic [ROW_W-1:0] r; } xfer_t;

  int              ack_delay = 2;
  bit              force_ack = 1'b0;
  int              age = 0;
  bit              prev_req = 1'b0, prev_ack = 1'b0, prev_erase = 1'b0, prev_go = 1'b0;
  logic [ROW_W-1:0] prev_row = '0;
  xfer_t           xfer_q[$];
  int              load_cyc[$];
  int              step_cyc[$];
  int              go_cyc = -1, first_req_cyc = -1, stab_err = 0;
  bit              ov_at_load, ov_at_go, won_at_go;
  logic [15:0]     fc_at_load, fc_at_go;

  task automatic mon_step();
    if (draw_req && prev_req && !prev_ack && (draw_row != prev_row || erase != prev_erase))
      stab_err++;
    if (force_ack) draw_ack = 1'b1;
    else if (!draw_req) begin
      age = 0;
      draw_ack = 1'b0;
    end else begin
      if (!prev_req || prev_ack) age = 0;
      else age++;
      draw_ack = (age >= ack_delay);
    end
    if (draw_req && draw_ack) xfer_q.push_back({erase, draw_row});
    if (draw_req && !prev_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (load_song) begin
      load_cyc.push_back(cyc);
      ov_at_load = overrun;
      fc_at_load = frame_count;
    end
    if (logic_step) step_cyc.push_back(cyc);
    if (game_over && !prev_go) begin
      go_cyc    = cyc;
      ov_at_go  = overrun;
      fc_at_go  = frame_count;
      won_at_go = game_won;
    end
    prev_go = game_over; prev_req = draw_req; prev_ack = draw_ack;
    prev_row = draw_row; prev_erase = erase;
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  // First frame tick at or after cycle c, for a game whose LOAD cycle is L.
  function automatic int next_tick(input int L, input int c);
    int t0 = L + FRAME_CYCLES - 1;
    if (c <= t0) return t0;
    return t0 + ((c - t0 + FRAME_CYCLES - 1) / FRAME_CYCLES) * FRAME_CYCLES;
  endfunction

  // One game: n_norm ordinary frames (done after k_norm cycles), then a final
  // frame whose done arrives after k_last cycles (never if k_last > K_MAX).
  task automatic play_game(input int d, input int n_norm, input int k_norm, input int k_last,
                           input bit wl, input bit ll, input bit toggle_mid,
                           input int exp_fc, input bit exp_won, input int exp_xfers);
    int s, L, c, t, stp, w, g, fc_pred, started, nt, n, bad;
    bit ov_pred;
    xfer_t exp_q[$];
    @(negedge clk); start = 1'b0; ack_delay = d;
    @(negedge clk);
    xfer_q.delete(); load_cyc.delete(); step_cyc.delete();
    go_cyc = -1; first_req_cyc = -1; stab_err = 0;
    @(negedge clk); start = 1'b1; s = cyc;
    if (toggle_mid) begin
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk); start = 1'b1;
    end
    for (int i = 0; i <= n_norm; i++) begin
      bit last;
      int k;
      last = (i == n_norm);
      k = last ? k_last : k_norm;
      n = 0;
      while (!logic_step && n < WAIT_BOUND) begin @(negedge clk); n++; end
      if (!logic_step) begin chk("step_wait", logic_step, 1); return; end
      if (k <= K_MAX) begin
        repeat (k + 1) @(negedge clk);
        logic_done = 1'b1; won = last ? wl : 1'b0; lost = last ? ll : 1'b0;
        @(negedge clk);
        logic_done = 1'b0; won = 1'b0; lost = 1'b0;
      end
    end
    n = 0;
    while (!game_over && n < WAIT_BOUND) begin @(negedge clk); n++; end
    if (!game_over) begin chk("game_over_wait", game_over, 1); return; end
    @(negedge clk);

    // Reference timeline: LOAD at s+1, ticks every FRAME_CYCLES from L+FRAME_CYCLES-1.
    L = s + 1; c = L + 1; started = 0; fc_pred = 0; g = 0;
    for (int i = 0; i <= n_norm; i++) begin
      t = next_tick(L, c);
      started++;
      for (int r = 0; r < NUM_ROWS; r++) exp_q.push_back({1'b1, ROW_W'(r)});
      stp = t + 1 + NUM_ROWS * (d + 1);
      w = stp + 1;
      if (i == n_norm) begin
        g = (k_last > K_MAX) ? w + LOGIC_TIMEOUT - 1 : w + k_last + 1;
      end else begin
        for (int r = 0; r < NUM_ROWS; r++) exp_q.push_back({1'b0, ROW_W'(r)});
        fc_pred++;
        c = w + k_norm + NUM_ROWS * (d + 1) + 1;
      end
    end
    nt = (g - 1 < L + FRAME_CYCLES - 1) ? 0 : (g - L - FRAME_CYCLES) / FRAME_CYCLES + 1;
    ov_pred = (nt > started);

    chk("load_pulses", load_cyc.size(), 1);
    if (load_cyc.size() > 0) chk("load_cycle", load_cyc[0], s + 1);
    chk("overrun_at_load", ov_at_load, 0);
    chk("fc_at_load", fc_at_load, 0);
    chk("first_req_cycle", first_req_cyc, L + FRAME_CYCLES);
    chk("xfer_count", xfer_q.size(), exp_xfers);
    bad = (xfer_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < xfer_q.size() && i < exp_q.size(); i++)
      if (xfer_q[i] != exp_q[i]) bad++;
    chk("xfer_sequence", bad, 0);
    chk("step_count", step_cyc.size(), started);
    chk("game_over_cycle", go_cyc, g);
    chk("frame_count", fc_at_go, exp_fc);
    chk("game_won", won_at_go, exp_won);
    chk("overrun", ov_at_go, ov_pred);
    chk("handshake_stable", stab_err, 0);
    if (k_last > K_MAX && step_cyc.size() > 0)
      chk("timeout_latency", go_cyc - step_cyc[step_cyc.size() - 1], LOGIC_TIMEOUT);
  endtask

  typedef struct {
    int d; int n_norm; int k_norm; int k_last; bit wl; bit ll;
    int exp_fc; bit exp_won; int exp_xfers;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nn, kn, kl, pick, stuck;
    bit wl, ll;
    vecs[0] = '{2,  1, 0, 1,         1'b1, 1'b0, 1, 1'b1, 15};  // normal frame then won
    vecs[1] = '{2,  0, 0, 0,         1'b1, 1'b1, 0, 1'b0, 5};   // won+lost -> lost
    vecs[2] = '{0,  0, 0, K_MAX + 1, 1'b0, 1'b0, 0, 1'b0, 5};   // engine never answers
    vecs[3] = '{15, 2, 3, 3,         1'b0, 1'b1, 2, 1'b0, 25};  // slow renderer, overrun
    vecs[4] = '{1,  3, 2, K_MAX,     1'b1, 1'b0, 3, 1'b1, 35};  // done on last allowed cycle

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", all_outs(), 0);

    foreach (vecs[i])
      play_game(vecs[i].d, vecs[i].n_norm, vecs[i].k_norm, vecs[i].k_last,
                vecs[i].wl, vecs[i].ll, 1'b0,
                vecs[i].exp_fc, vecs[i].exp_won, vecs[i].exp_xfers);

    for (int it = 0; it < 8; it++) begin
      d    = ($urandom_range(0, 4) == 4) ? 15 : int'($urandom_range(0, 3));
      nn   = $urandom_range(0, 3);
      kn   = $urandom_range(0, K_MAX);
      kl   = $urandom_range(0, K_MAX + 2);
      pick = $urandom_range(0, 2);
      wl   = (pick != 1);
      ll   = (pick != 0);
      play_game(d, nn, kn, kl, wl, ll, 1'($urandom_range(0, 1)),
                nn, (kl <= K_MAX) && wl && !ll, NUM_ROWS * (2 * nn + 1));
    end

    // Reset in the middle of a draw pass.
    @(negedge clk); start = 1'b0; ack_delay = 15;
    @(negedge clk); start = 1'b1;
    stuck = 0;
    while (!logic_step && stuck < WAIT_BOUND) begin @(negedge clk); stuck++; end
    chk("rst_test_step", logic_step, 1);
    @(negedge clk); logic_done = 1'b1;
    @(negedge clk); logic_done = 1'b0;
    stuck = 0;
    while (!(draw_req && !erase) && stuck < WAIT_BOUND) begin @(negedge clk); stuck++; end
    chk("rst_test_in_draw", draw_req && !erase, 1);
    resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("mid_draw_reset_outputs", all_outs(), 0);
    resetn = 1'b1; force_ack = 1'b1;
    stuck = 0;
    load_cyc.delete();
    repeat (6) begin
      @(negedge clk);
      if (all_outs() != 0) stuck++;
    end
    force_ack = 1'b0;
    chk("stray_ack_ignored", stuck, 0);
    chk("no_load_after_reset", load_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
